uint8: RTL and testbench

- Single 8-bit unsigned storage register. One instance holds one matrix or filter element.
- The ram block instantiates 25 of these: a00..a33 (4x4 input data) and b00..b22 (3x3 filter). Their outputs feed the systolic-array convolution datapath.
- Also used as the generic pipeline or accumulator storage cell in that datapath, so it provides a reset and a synchronous clear.

---
 rtl/uint8_pkg.sv | 11 +
 rtl/uint8_bit.sv | 33 +++
 rtl/uint8.sv | 38 +++
 tb/tb_uint8.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uint8_pkg.sv
// Shared definitions for the convolution datapath storage cells.
// Holds the data width, the unsigned element type and the reset constant.
package uint8_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] u8_t;

    localparam u8_t ZERO = '0;

endpackage

// File: rtl/uint8_bit.sv
// One storage bit: async active-high reset, sync clear, otherwise loads d_i every edge.
// Reused as the per-bit template for the wider accumulator cells in the array.
module uint8_bit
    import uint8_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic d_i,
    output logic q_o
);

    logic q_d;
    logic q_q;

    // Clear takes priority over the data load; reset overrides both asynchronously.
    always_comb begin
        q_d = clear_i ? RESET_BIT : d_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/uint8.sv
// WIDTH-bit unsigned storage register built from uint8_bit cells.
// out comes straight from the flops; in and clear only reach out through a clock edge.
module uint8
    import uint8_pkg::*;
#(
    parameter int          WIDTH       = DATA_W,
    parameter logic [63:0] RESET_VALUE = 64'(ZERO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("uint8: WIDTH must be in 1..64");
    end

    if (WIDTH < 64) begin : g_rv_chk
        if ((RESET_VALUE >> WIDTH) != 64'd0) begin : g_bad_rv
            $error("uint8: RESET_VALUE does not fit in WIDTH bits");
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        uint8_bit #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_bit (
            .clk_i  (clk),
            .rst_i  (rst),
            .clear_i(clear),
            .d_i    (in[i]),
            .q_o    (out[i])
        );
    end

endmodule

// File: tb/tb_uint8.sv
// Scoreboard bench for uint8: driver pushes expected out values, monitor pops and compares mid-cycle.
// Also checks a bank of 25 constant-input instances the way the ram block uses them.
module tb_uint8;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [7:0] in;
    logic [7:0] out;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    int passed = 0;
    int total  = 0;

    localparam logic [7:0] CONSTS [25] = '{
        8'd9, 8'd8, 8'd2, 8'd6, 8'd0, 8'd4, 8'd1, 8'd6,
        8'd4, 8'd10, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9,
        8'd3, 8'd2, 8'd0, 8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd1
    };

    logic [7:0] cout [25];

    uint8 dut (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .in   (in),
        .out  (out)
    );

    for (genvar g = 0; g < 25; g++) begin : g_const
        uint8 u_c (
            .clk  (clk),
            .rst  (1'b0),
            .clear(1'b0),
            .in   (CONSTS[g]),
            .out  (cout[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: value held after the most recent rising edge.
    logic [7:0] m;
    logic       prev_rst, prev_clear;
    logic [7:0] prev_in;

    task automatic step(input logic r, input logic c, input logic [7:0] d, input string name);
        exp_t e;
        @(posedge clk);
        if (prev_rst || prev_clear) m = 8'h00;
        else                        m = prev_in;
        #2;
        rst   = r;
        clear = c;
        in    = d;
        if (r) m = 8'h00;
        prev_rst   = r;
        prev_clear = c;
        prev_in    = d;
        e.exp  = m;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compares the main DUT against the scoreboard and the constant bank against its table.
    int const_cycles = 0;
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (out === e.exp) passed++;
                else $display("FAIL %s: out=%h expected=%h at %0t", e.name, out, e.exp, $time);
            end
            if (const_cycles < 100) begin
                for (int k = 0; k < 25; k++) begin
                    total++;
                    if (cout[k] === CONSTS[k]) passed++;
                    else $display("FAIL const[%0d]: out=%h expected=%h at %0t", k, cout[k], CONSTS[k], $time);
                end
                const_cycles++;
            end
        end
    end

    initial begin
        logic r, c;
        logic [7:0] d;
        rst = 1'b1; clear = 1'b0; in = 8'h00;
        prev_rst = 1'b1; prev_clear = 1'b0; prev_in = 8'h00; m = 8'h00;

        step(1, 0, 8'h00, "reset");
        // Load
        step(0, 0, 8'h09, "load_pre");
        step(0, 0, 8'h09, "load_09");
        step(0, 0, 8'hFF, "load_hold");
        step(0, 0, 8'hFF, "load_FF");
        // Async reset
        step(0, 0, 8'hA5, "ar_pre");
        step(0, 0, 8'hA5, "ar_A5");
        step(1, 0, 8'h3C, "ar_async");
        step(1, 0, 8'h3C, "ar_hold");
        step(0, 0, 8'h3C, "ar_release");
        step(0, 0, 8'h3C, "ar_load");
        // Sync clear
        step(0, 0, 8'h7E, "clr_pre");
        step(0, 1, 8'h11, "clr_before_edge");
        step(0, 0, 8'h11, "clr_after_edge");
        step(0, 0, 8'h11, "clr_reload");
        // Priority
        step(1, 1, 8'h55, "prio_rst_clr");
        step(0, 1, 8'h55, "prio_rel_rst");
        step(0, 0, 8'h55, "prio_clr_wins");
        step(0, 0, 8'h55, "prio_load");
        // Boundaries
        step(0, 0, 8'h00, "bnd_00");
        step(0, 0, 8'h80, "bnd_80");
        step(0, 0, 8'hFF, "bnd_FF");
        step(0, 0, 8'hFF, "bnd_last");
        // Random
        for (int i = 0; i < 1000; i++) begin
            r = ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 7) == 0);
            d = 8'($urandom);
            step(r, c, d, "random");
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        wait (const_cycles >= 100);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
